// File: rtl/fixed_p_std_sdiv_pipe.sv
// -----------------------------------------------------------------------------
// fixed_p_std_sdiv_pipe
//
// Multi-cycle signed fixed-point divider with a Calyx-style go/done handshake.
// It runs a restoring division over N = WIDTH + FRACT_WIDTH iterations, one
// quotient bit per clock. The quotient keeps FRACT_WIDTH fractional bits and
// is truncated toward zero.
//
// Divide-by-zero returns the saturated value that matches the dividend's sign
// and sets div_by_zero. Out-of-range quotients set overflow. In that case the
// result is either clamped (SATURATE = 1) or wrapped to the low WIDTH bits of
// the signed quotient (SATURATE = 0).
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low; aborts any operation in flight
//   go           start request, sampled only while idle
//   left         signed dividend (two's complement, WIDTH bits)
//   right        signed divisor
//   out          signed quotient, held until the next result is written
//   overflow     last result exceeded the representable range
//   div_by_zero  last operation had right == 0
//   done         one-cycle pulse; out and flags are valid
// -----------------------------------------------------------------------------
module fixed_p_std_sdiv_pipe #(
    parameter int WIDTH       = 32,
    parameter int INT_WIDTH   = 8,
    parameter int FRACT_WIDTH = 24,
    parameter int SATURATE    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic [WIDTH-1:0] out,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             done
);

    localparam int N  = WIDTH + FRACT_WIDTH;   // iterations / quotient width
    localparam int RW = WIDTH + 1;             // remainder width
    localparam int CW = $clog2(N);

    localparam logic [WIDTH-1:0] MAX_POS =
        WIDTH'({1'b0, {(INT_WIDTH-1){1'b1}}, {FRACT_WIDTH{1'b1}}});
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_sign;
    logic [WIDTH-1:0] r_dvs;     // |right|
    logic [N-1:0]     r_dvd;     // dividend bits out of the MSB, quotient bits in at the LSB
    logic [RW-1:0]    r_rem;
    logic [WIDTH-1:0] r_out;
    logic             r_ovf;
    logic             r_dbz;
    logic             r_done;

    // Operand magnitudes. The most negative value maps to 2^(WIDTH-1), which
    // still fits as an unsigned WIDTH-bit number.
    logic [WIDTH-1:0] w_abs_l;
    logic [WIDTH-1:0] w_abs_r;
    logic [WIDTH-1:0] w_dz_res;

    // One restoring step.
    logic [RW:0]      w_rem_sh;
    logic [RW:0]      w_dvs_ext;
    logic             w_ge;
    logic [RW-1:0]    w_rem_nx;
    logic [N-1:0]     w_q_nx;
    logic             w_last;

    // Result formatting on the final step.
    logic [N-1:0]     w_lim;
    logic             w_ovf;
    logic [WIDTH-1:0] w_q_lo;
    logic [WIDTH-1:0] w_wrap;
    logic [WIDTH-1:0] w_res;

    always_comb begin
        w_abs_l  = left[WIDTH-1]  ? (~left  + 1'b1) : left;
        w_abs_r  = right[WIDTH-1] ? (~right + 1'b1) : right;
        w_dz_res = left[WIDTH-1]  ? MIN_NEG : MAX_POS;

        w_rem_sh  = {r_rem, r_dvd[N-1]};
        w_dvs_ext = {2'b00, r_dvs};
        w_ge      = (w_rem_sh >= w_dvs_ext);
        // The remainder stays below |right| <= 2^(WIDTH-1), so it always fits in RW bits.
        w_rem_nx  = w_ge ? RW'(w_rem_sh - w_dvs_ext) : RW'(w_rem_sh);
        // Each consumed dividend bit frees one LSB slot for the next quotient bit.
        // After N steps, the register holds Q.
        w_q_nx    = {r_dvd[N-2:0], w_ge};
        w_last    = (r_cnt == CW'(N-1));

        // A negative result can reach one step further than a positive one.
        w_lim  = N'(r_sign ? MIN_NEG : MAX_POS);
        w_ovf  = (w_q_nx > w_lim);
        w_q_lo = w_q_nx[WIDTH-1:0];
        w_wrap = r_sign ? (~w_q_lo + 1'b1) : w_q_lo;
        w_res  = (w_ovf && (SATURATE != 0)) ? (r_sign ? MIN_NEG : MAX_POS) : w_wrap;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sign  <= 1'b0;
            r_dvs   <= '0;
            r_dvd   <= '0;
            r_rem   <= '0;
            r_out   <= '0;
            r_ovf   <= 1'b0;
            r_dbz   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        r_sign <= left[WIDTH-1] ^ right[WIDTH-1];
                        if (right == '0) begin
                            // No iterations are needed. Publish the result right away.
                            r_out   <= w_dz_res;
                            r_ovf   <= 1'b0;
                            r_dbz   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_dvs   <= w_abs_r;
                            r_dvd   <= {w_abs_l, {FRACT_WIDTH{1'b0}}};
                            r_rem   <= '0;
                            r_cnt   <= '0;
                            r_state <= S_CALC;
                        end
                    end
                end

                S_CALC: begin
                    r_rem <= w_rem_nx;
                    r_dvd <= w_q_nx;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_out   <= w_res;
                        r_ovf   <= w_ovf;
                        r_dbz   <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end

                S_DONE: begin
                    // go is ignored here. A held go restarts on the following idle edge.
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out         = r_out;
    assign overflow    = r_ovf;
    assign div_by_zero = r_dbz;
    assign done        = r_done;

endmodule
